switch_arbiter_rr_lock: RTL and testbench

//  Parametrised N-port crossbar arbiter for the packet switch. It keeps per-output

---
 rtl/packet_pkg.sv | 8 +
 rtl/switch_arbiter_rr_lock_rr_pick.sv | 24 ++
 rtl/switch_arbiter_rr_lock.sv | 146 ++++++++++++++
 tb/tb_switch_arbiter_rr_lock.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Shared packet-switch types: port index and port mask at the default port count.
package packet_pkg;
    localparam int NUM_PORTS_DEF = 4;
    localparam int SEL_W_DEF     = $clog2(NUM_PORTS_DEF);

    typedef logic [SEL_W_DEF-1:0]     port_idx_t;
    typedef logic [NUM_PORTS_DEF-1:0] port_mask_t;
endpackage

// File: rtl/switch_arbiter_rr_lock_rr_pick.sv
// Combinational round-robin picker: one-hot winner among i_req, searching upward from i_ptr.
module rr_pick #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic [N-1:0]  o_win
);
    always_comb begin
        logic          found;
        logic [SW-1:0] idx;
        o_win = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = SW'((int'(i_ptr) + k) % N);
            if (!found && i_req[idx]) begin
                o_win[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_arbiter_rr_lock.sv
// Crossbar arbiter: per-output round-robin, all-or-nothing multicast grants, locks held until eop,
// and a single starvation reservation that keeps other inputs off the starved input's outputs.
module switch_arbiter_rr_lock
    import packet_pkg::*;
#(
    parameter int  NUM_PORTS    = NUM_PORTS_DEF,
    parameter int  STARVE_LIMIT = 16,
    localparam int SEL_W        = $clog2(NUM_PORTS),
    localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] req_dst,
    input  logic [NUM_PORTS-1:0]           eop,
    output logic [NUM_PORTS-1:0]           grant,
    output logic [NUM_PORTS*SEL_W-1:0]     mux_sel,
    output logic [NUM_PORTS-1:0]           active,
    output logic [NUM_PORTS-1:0]           starved
);
    logic [SEL_W-1:0]     r_owner [NUM_PORTS];
    logic [SEL_W-1:0]     r_ptr   [NUM_PORTS];
    logic [CNT_W-1:0]     r_wait  [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_active;
    logic                 r_resv_vld;
    logic [SEL_W-1:0]     r_resv_idx;

    logic [NUM_PORTS-1:0] w_mask [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_cand [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_win  [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_busy;
    logic [NUM_PORTS-1:0] w_grant;
    logic [NUM_PORTS-1:0] w_starved;
    logic [NUM_PORTS-1:0] w_resv_sel;

    assign w_resv_sel = NUM_PORTS'(1) << r_resv_idx;

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_mask[i] = req_dst[i*NUM_PORTS +: NUM_PORTS];
            if (r_active[i]) w_busy[r_owner[i]] = 1'b1;
        end
    end

    // Candidates per output: free outputs only, idle requesters only, narrowed to the reserved input.
    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_cand[j] = '0;
            for (int i = 0; i < NUM_PORTS; i++)
                w_cand[j][i] = w_mask[i][j] & ~w_busy[i] & ~r_active[j];
            if (r_resv_vld && w_mask[r_resv_idx][j])
                w_cand[j] = w_cand[j] & w_resv_sel;
        end
    end

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_pick
        rr_pick #(.N(NUM_PORTS), .SW(SEL_W)) u_pick (
            .i_req (w_cand[j]),
            .i_ptr (r_ptr[j]),
            .o_win (w_win[j])
        );
        assign mux_sel[j*SEL_W +: SEL_W] = r_owner[j];
    end

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_grant[i] = (w_mask[i] != '0) & ~w_busy[i];
            for (int j = 0; j < NUM_PORTS; j++)
                if (w_mask[i][j] && !w_win[j][i]) w_grant[i] = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            w_starved[i] = (r_wait[i] == CNT_W'(STARVE_LIMIT));
    end

    // Release on eop is applied before new locks; grants only ever target outputs that were free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '0;
            for (int j = 0; j < NUM_PORTS; j++) r_owner[j] <= '0;
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (r_active[j] && eop[r_owner[j]]) begin
                    r_active[j] <= 1'b0;
                    r_owner[j]  <= '0;
                end
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (w_grant[i] && w_mask[i][j]) begin
                        r_active[j] <= 1'b1;
                        r_owner[j]  <= SEL_W'(i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NUM_PORTS; j++) r_ptr[j] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++)
                for (int j = 0; j < NUM_PORTS; j++)
                    if (w_grant[i] && w_mask[i][j]) r_ptr[j] <= SEL_W'((i + 1) % NUM_PORTS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) r_wait[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!w_busy[i]) begin
                    if (w_grant[i] || w_mask[i] == '0)
                        r_wait[i] <= '0;
                    else if (!w_starved[i])
                        r_wait[i] <= r_wait[i] + CNT_W'(1);
                end
            end
        end
    end

    // Descending scan so the lowest-index starved input ends up holding the reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resv_vld <= 1'b0;
            r_resv_idx <= '0;
        end else if (r_resv_vld) begin
            if (w_grant[r_resv_idx] || w_mask[r_resv_idx] == '0)
                r_resv_vld <= 1'b0;
        end else begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (w_starved[i]) begin
                    r_resv_vld <= 1'b1;
                    r_resv_idx <= SEL_W'(i);
                end
            end
        end
    end

    assign grant   = w_grant;
    assign active  = r_active;
    assign starved = w_starved;
endmodule

// File: tb/tb_switch_arbiter_rr_lock.sv
// Bench for switch_arbiter_rr_lock: directed vector table, hand sequences and random traffic
// checked against a behavioural arbiter model.
module tb_switch_arbiter_rr_lock;
    import packet_pkg::*;

    localparam int N   = 4;
    localparam int LIM = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_dst;
    logic [3:0]  eop;
    logic [3:0]  grant, active, starved;
    logic [7:0]  mux_sel;
    logic [3:0]  grant4, active4, starved4;
    logic [7:0]  mux_sel4;

    always #5 clk = ~clk;

    switch_arbiter_rr_lock #(.NUM_PORTS(N), .STARVE_LIMIT(LIM)) u_dut (
        .clk(clk), .rst(rst), .req_dst(req_dst), .eop(eop),
        .grant(grant), .mux_sel(mux_sel), .active(active), .starved(starved)
    );

    switch_arbiter_rr_lock #(.NUM_PORTS(N), .STARVE_LIMIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_dst(req_dst), .eop(eop),
        .grant(grant4), .mux_sel(mux_sel4), .active(active4), .starved(starved4)
    );

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model state: owner per output (-1 = free), pointers, waits, reserved input (-1 = none).
    int m_owner [N];
    int m_ptr   [N];
    int m_wait  [N];
    int m_resv;

    logic [3:0] s_g, s_a, s_st, s_g4, s_a4, s_st4;
    logic [7:0] s_mx, s_mx4;

    typedef struct {
        logic [15:0] req;
        logic [3:0]  ev;
        logic [3:0]  g;
        logic [3:0]  a;
        logic [7:0]  mx;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [15:0] rq, input logic [3:0] ev, input logic [3:0] g,
                                 input logic [3:0] a, input logic [7:0] mx);
        vec_t v;
        v.req = rq; v.ev = ev; v.g = g; v.a = a; v.mx = mx;
        return v;
    endfunction

    function automatic logic [15:0] rqv(input port_mask_t m0, input port_mask_t m1,
                                        input port_mask_t m2, input port_mask_t m3);
        return {m3, m2, m1, m0};
    endfunction

    function automatic port_mask_t mask_of(input logic [15:0] rq, input int i);
        return rq[i*N +: N];
    endfunction

    function automatic logic [7:0] muxmask(input logic [3:0] a);
        logic [7:0] mm;
        for (int j = 0; j < N; j++) mm[j*2 +: 2] = a[j] ? 2'b11 : 2'b00;
        return mm;
    endfunction

    function automatic void m_reset();
        for (int j = 0; j < N; j++) begin
            m_owner[j] = -1; m_ptr[j] = 0; m_wait[j] = 0;
        end
        m_resv = -1;
    endfunction

    function automatic bit m_busy(input int i);
        for (int j = 0; j < N; j++) if (m_owner[j] == i) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pick(input logic [15:0] rq, input int j);
        int c;
        if (m_resv >= 0 && rq[m_resv*N + j])
            return m_busy(m_resv) ? -1 : m_resv;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr[j] + k) % N;
            if (rq[c*N + j] && !m_busy(c)) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_grant(input logic [15:0] rq);
        logic [3:0] g;
        port_mask_t m;
        g = '0;
        for (int i = 0; i < N; i++) begin
            m = mask_of(rq, i);
            if (m != 0 && !m_busy(i)) begin
                g[i] = 1'b1;
                for (int j = 0; j < N; j++)
                    if (m[j] && (m_owner[j] >= 0 || m_pick(rq, j) != i)) g[i] = 1'b0;
            end
        end
        return g;
    endfunction

    function automatic void m_advance(input logic r, input logic [15:0] rq, input logic [3:0] ev,
                                      input logic [3:0] g);
        bit bp [N];
        bit taken;
        if (r) begin
            m_reset();
            return;
        end
        for (int i = 0; i < N; i++) bp[i] = m_busy(i);
        if (m_resv >= 0) begin
            if (g[m_resv] || mask_of(rq, m_resv) == 0) m_resv = -1;
        end else begin
            taken = 1'b0;
            for (int i = 0; i < N; i++)
                if (!taken && m_wait[i] == LIM) begin
                    m_resv = i; taken = 1'b1;
                end
        end
        for (int i = 0; i < N; i++)
            if (!bp[i]) begin
                if (g[i] || mask_of(rq, i) == 0) m_wait[i] = 0;
                else if (m_wait[i] < LIM) m_wait[i]++;
            end
        for (int j = 0; j < N; j++)
            if (m_owner[j] >= 0 && ev[m_owner[j]]) m_owner[j] = -1;
        for (int i = 0; i < N; i++)
            if (g[i])
                for (int j = 0; j < N; j++)
                    if (rq[i*N + j]) begin
                        m_owner[j] = i;
                        m_ptr[j]   = (i + 1) % N;
                    end
    endfunction

    // One cycle: drive after the edge, sample and check mid-cycle, advance the model at the edge.
    task automatic step(input logic r, input logic [15:0] rq, input logic [3:0] ev);
        logic [3:0] eg, ea, est;
        logic [7:0] emx;
        rst = r; req_dst = rq; eop = ev;
        #4;
        eg = m_grant(rq);
        ea = '0; est = '0; emx = '0;
        for (int j = 0; j < N; j++) begin
            ea[j]  = (m_owner[j] >= 0);
            est[j] = (m_wait[j] == LIM);
            if (m_owner[j] >= 0) emx[j*2 +: 2] = 2'(m_owner[j]);
        end
        s_g = grant; s_a = active; s_st = starved; s_mx = mux_sel;
        s_g4 = grant4; s_a4 = active4; s_st4 = starved4; s_mx4 = mux_sel4;
        check("model.grant",   n_chk, 8'(s_g), 8'(eg));
        check("model.active",  n_chk, 8'(s_a), 8'(ea));
        check("model.mux_sel", n_chk, s_mx & muxmask(ea), emx);
        check("model.starved", n_chk, 8'(s_st), 8'(est));
        @(posedge clk);
        m_advance(r, rq, ev, eg);
        #1;
    endtask

    initial begin
        logic [15:0] rq;
        logic [3:0]  ev, eg;
        logic        r;

        tbl[0]  = mkv(16'h0,                          4'b0000, 4'b0000, 4'b0000, 8'h00);
        tbl[1]  = mkv(rqv(4'b0010, 4'b0010, 0, 0),    4'b0000, 4'b0001, 4'b0000, 8'h00);
        tbl[2]  = mkv(rqv(0, 4'b0010, 0, 0),          4'b0000, 4'b0000, 4'b0010, 8'h00);
        tbl[3]  = mkv(rqv(0, 4'b0010, 0, 0),          4'b0001, 4'b0000, 4'b0010, 8'h00);
        tbl[4]  = mkv(rqv(0, 4'b0010, 0, 0),          4'b0000, 4'b0010, 4'b0000, 8'h00);
        tbl[5]  = mkv(16'h0,                          4'b0010, 4'b0000, 4'b0010, 8'b0000_0100);
        tbl[6]  = mkv(rqv(0, 0, 4'b1000, 0),          4'b0000, 4'b0100, 4'b0000, 8'h00);
        tbl[7]  = mkv(rqv(4'b1111, 0, 0, 0),          4'b0000, 4'b0000, 4'b1000, 8'b1000_0000);
        tbl[8]  = mkv(rqv(4'b1111, 0, 0, 0),          4'b0100, 4'b0000, 4'b1000, 8'b1000_0000);
        tbl[9]  = mkv(rqv(4'b1111, 0, 0, 0),          4'b0000, 4'b0001, 4'b0000, 8'h00);
        tbl[10] = mkv(16'h0,                          4'b0000, 4'b0000, 4'b1111, 8'h00);
        tbl[11] = mkv(16'h0,                          4'b0010, 4'b0000, 4'b1111, 8'h00);
        tbl[12] = mkv(16'h0,                          4'b0000, 4'b0000, 4'b1111, 8'h00);
        tbl[13] = mkv(16'h0,                          4'b0001, 4'b0000, 4'b1111, 8'h00);
        tbl[14] = mkv(16'h0,                          4'b0000, 4'b0000, 4'b0000, 8'h00);

        rst = 1'b1; req_dst = '0; eop = '0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();

        for (int k = 0; k < 15; k++) begin
            step(1'b0, tbl[k].req, tbl[k].ev);
            check("tbl.grant",   k, 8'(s_g), 8'(tbl[k].g));
            check("tbl.active",  k, 8'(s_a), 8'(tbl[k].a));
            check("tbl.mux_sel", k, s_mx & muxmask(tbl[k].a), tbl[k].mx);
            check("tbl.starved", k, 8'(s_st), 8'h00);
        end

        // Four ports contend for output 2, each packet ends the cycle after its grant.
        step(1'b1, 16'h0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            step(1'b0, rqv(4'b0100, 4'b0100, 4'b0100, 4'b0100), 4'b0000);
            check("rr.grant", k, 8'(s_g), 8'(eg));
            step(1'b0, rqv(4'b0100, 4'b0100, 4'b0100, 4'b0100), eg);
            check("rr.hold", k, 8'(s_g), 8'h00);
        end

        // Reset while outputs 0 and 2 are locked.
        step(1'b1, 16'h0, 4'b0000);
        step(1'b0, rqv(0, 4'b0001, 0, 4'b0100), 4'b0000);
        check("rst.pre_grant", 0, 8'(s_g), 8'b0000_1010);
        step(1'b0, 16'h0, 4'b0000);
        check("rst.pre_active", 0, 8'(s_a), 8'b0000_0101);
        check("rst.pre_mux", 0, s_mx & muxmask(4'b0101), 8'b0011_0001);
        step(1'b1, 16'h0, 4'b0000);
        step(1'b0, rqv(0, 0, 0, 4'b0001), 4'b0000);
        check("rst.active", 0, 8'(s_a), 8'h00);
        check("rst.mux_sel", 0, s_mx, 8'h00);
        check("rst.starved", 0, 8'(s_st), 8'h00);
        check("rst.grant", 0, 8'(s_g), 8'b0000_1000);
        step(1'b0, 16'h0, 4'b0000);
        check("rst.relock", 0, 8'(s_a), 8'b0000_0001);
        check("rst.relock_mux", 0, s_mx & muxmask(4'b0001), 8'b0000_0011);

        // Starvation on the limit-4 instance: port 0 wants outputs 0+1 while they stay busy.
        step(1'b1, 16'h0, 4'b0000);
        step(1'b0, rqv(0, 4'b0001, 4'b0010, 0), 4'b0000);
        check("starve.setup", 0, 8'(s_g4), 8'b0000_0110);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, rqv(4'b0011, 0, 0, 0), 4'b0000);
            check("starve.early", k, 8'(s_st4), 8'h00);
        end
        step(1'b0, rqv(4'b0011, 0, 0, 0), 4'b0000);
        check("starve.flag", 5, 8'(s_st4), 8'b0000_0001);
        step(1'b0, rqv(4'b0011, 0, 0, 0), 4'b0010);
        check("starve.flag", 6, 8'(s_st4), 8'b0000_0001);
        check("starve.grant", 6, 8'(s_g4), 8'h00);
        step(1'b0, rqv(4'b0011, 0, 0, 4'b0001), 4'b0000);
        check("starve.block_grant", 7, 8'(s_g4), 8'h00);
        check("starve.block_active", 7, 8'(s_a4), 8'b0000_0010);
        step(1'b0, rqv(4'b0011, 0, 0, 4'b0001), 4'b0100);
        check("starve.block_grant", 8, 8'(s_g4), 8'h00);
        check("starve.block_active", 8, 8'(s_a4), 8'b0000_0010);
        step(1'b0, rqv(4'b0011, 0, 0, 4'b0001), 4'b0000);
        check("starve.win", 9, 8'(s_g4), 8'b0000_0001);
        check("starve.win_active", 9, 8'(s_a4), 8'h00);
        step(1'b0, 16'h0, 4'b0000);
        check("starve.locked", 10, 8'(s_a4), 8'b0000_0011);
        check("starve.locked_mux", 10, s_mx4 & muxmask(4'b0011), 8'h00);
        check("starve.cleared", 10, 8'(s_st4), 8'h00);

        // Random multicast traffic against the model.
        step(1'b1, 16'h0, 4'b0000);
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 299) == 0);
            rq = '0;
            ev = '0;
            for (int i = 0; i < N; i++) begin
                if (m_busy(i)) begin
                    ev[i] = ($urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 3) == 0) rq[i*N +: N] = 4'($urandom);
                end else begin
                    ev[i] = ($urandom_range(0, 15) == 0);
                    if ($urandom_range(0, 3) != 0) rq[i*N +: N] = 4'($urandom & $urandom);
                end
            end
            step(r, rq, ev);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
